// File: rtl/selftest_pkg.sv
// Shared types for the self-test sequencer: sweep FSM states and a width helper
// used to size index and timer registers.
package selftest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RECORD,
        DONE
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int widthOf(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Per-test watchdog: counts cycles while enabled and flags the last allowed
// cycle so the sequencer can fail an engine that never answers.
module timeout_counter
    import selftest_pkg::*;
#(
    parameter int LIMIT = 20000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = widthOf(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    // Saturating count so a stalled FSM can never wrap back into range.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/selftest_sequencer.sv
// Runs each unit self-test engine in turn, enforces a per-test timeout and
// collects pass/timeout vectors plus an all-passed flag for board readout.
module selftest_sequencer
    import selftest_pkg::*;
#(
    parameter int NUM_TESTS      = 10,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           run,
    input  logic                           abort,
    output logic [NUM_TESTS-1:0]           test_start,
    input  logic [NUM_TESTS-1:0]           test_done,
    input  logic [NUM_TESTS-1:0]           test_pass,
    output logic                           busy,
    output logic                           done,
    output logic                           all_passed,
    output logic [NUM_TESTS-1:0]           result_vec,
    output logic [NUM_TESTS-1:0]           timeout_vec,
    output logic [widthOf(NUM_TESTS)-1:0]  current_idx
);

    localparam int IW = widthOf(NUM_TESTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TESTS - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_TESTS-1:0] result_q, result_d;
    logic [NUM_TESTS-1:0] timeout_q, timeout_d;
    logic                 pass_q, pass_d;
    logic                 timedOut_q, timedOut_d;
    logic                 allPassed_q, allPassed_d;
    logic                 expired;

    timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q == LAUNCH),
        .enable  (state_q == WAIT),
        .expired (expired)
    );

    assign busy = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == RECORD);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        result_d    = result_q;
        timeout_d   = timeout_q;
        pass_d      = pass_q;
        timedOut_d  = timedOut_q;
        allPassed_d = allPassed_q;
        case (state_q)
            IDLE, DONE: begin
                if (run) begin
                    result_d    = '0;
                    timeout_d   = '0;
                    idx_d       = '0;
                    allPassed_d = 1'b0;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                // A completion strobe in the expiry cycle still counts as an answer.
                if (test_done[idx_q]) begin
                    pass_d     = test_pass[idx_q];
                    timedOut_d = 1'b0;
                    state_d    = RECORD;
                end else if (expired) begin
                    pass_d     = 1'b0;
                    timedOut_d = 1'b1;
                    state_d    = RECORD;
                end
            end
            RECORD: begin
                result_d[idx_q]  = pass_q;
                timeout_d[idx_q] = timedOut_q;
                if (idx_q == LAST_IDX) begin
                    allPassed_d = &result_d;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (busy && abort) begin
            state_d     = IDLE;
            idx_d       = '0;
            result_d    = result_q;
            timeout_d   = timeout_q;
            allPassed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            result_q    <= '0;
            timeout_q   <= '0;
            pass_q      <= 1'b0;
            timedOut_q  <= 1'b0;
            allPassed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            timedOut_q  <= timedOut_d;
            allPassed_q <= allPassed_d;
        end
    end

    always_comb begin
        test_start = '0;
        if (state_q == LAUNCH) begin
            test_start[idx_q] = 1'b1;
        end
    end

    assign done        = (state_q == DONE);
    assign all_passed  = allPassed_q;
    assign result_vec  = result_q;
    assign timeout_vec = timeout_q;
    assign current_idx = idx_q;

endmodule
